// File: rtl/ram_burst_reader.sv
// ram_burst_reader: burst read controller turning a (addr, count) command into a valid/ready word stream
module ram_burst_reader #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_count,
  output logic                  ram_renable,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  pending, pending_last;
  logic [DATA_WIDTH-1:0] data0, data1;
  logic                  last0, last1;
  logic [1:0]            level;
  logic [2:0]            occupancy;
  logic                  pop, push, accept, issue, wr0, wr1, shift;
  // handshakes, issue throttle and buffer write/shift decisions
  always_comb begin
    pop       = (level != 2'd0) && out_ready;
    push      = pending;
    accept    = (state == IDLE) && cmd_valid;
    occupancy = {1'b0, level} + {2'b0, pending} - {2'b0, pop};
    issue     = (state == READ) && (remaining != '0) && (occupancy < 3'd2);
    wr0       = push && ((level == 2'd0) || ((level == 2'd1) && pop));
    wr1       = push && (((level == 2'd1) && !pop) || ((level == 2'd2) && pop));
    shift     = pop && (level == 2'd2);
  end
  // next-state logic and outputs
  always_comb begin
    state_next  = state;
    cmd_ready   = (state == IDLE);
    busy        = (state != IDLE);
    ram_renable = issue;
    ram_raddr   = addr_q;
    out_valid   = (level != 2'd0);
    out_data    = data0;
    out_last    = last0 && (level != 2'd0);
    case (state)
      IDLE:    state_next = accept ? READ : IDLE;
      READ:    state_next = (remaining == '0) ? DRAIN : READ;
      DRAIN:   state_next = (pop && last0) ? IDLE : DRAIN;
      default: state_next = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end
  // address and remaining-word counters; remaining is one bit wider so a full-depth burst fits
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      remaining <= '0;
    end else if (accept) begin
      addr_q    <= cmd_addr;
      remaining <= {1'b0, cmd_count} + (ADDR_WIDTH+1)'(1);
    end else if (issue) begin
      addr_q    <= addr_q + ADDR_WIDTH'(1);
      remaining <= remaining - (ADDR_WIDTH+1)'(1);
    end
  end
  // one read in flight: its data arrives on ram_rdata the cycle after issue
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending      <= 1'b0;
      pending_last <= 1'b0;
    end else begin
      pending      <= issue;
      pending_last <= issue && (remaining == (ADDR_WIDTH+1)'(1));
    end
  end
  // two-entry output FIFO, entry 0 is the presented head
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level <= 2'd0;
      data0 <= '0;
      last0 <= 1'b0;
      data1 <= '0;
      last1 <= 1'b0;
    end else begin
      level <= level + {1'b0, push} - {1'b0, pop};
      if (wr0) begin
        data0 <= ram_rdata;
        last0 <= pending_last;
      end else if (shift) begin
        data0 <= data1;
        last0 <= last1;
      end
      if (wr1) begin
        data1 <= ram_rdata;
        last1 <= pending_last;
      end
    end
  end
endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader: randomized bench comparing the burst reader against a queue-based reference model
module tb_ram_burst_reader;
  localparam int DW = 10;
  localparam int AW = 8;
  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW-1:0] cmd_count = '0;
  logic          ram_renable;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  ram_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_count(cmd_count),
    .ram_renable(ram_renable), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] mem [256];
  always @(posedge clock) if (ram_renable) ram_rdata <= mem[ram_raddr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  int rmode = 0;
  int pidx = 0;
  bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  initial forever begin
    @(posedge clock);
    #1;
    if (rmode == 0) out_ready = 1'b1;
    else if (rmode == 1) out_ready = pat[pidx % 7];
    else if (rmode == 2) out_ready = 1'($urandom_range(0, 1));
    else out_ready = 1'b0;
    pidx++;
  end

  logic [DW:0]   exp_q [$];
  bit            busy_m, pend_m, prev_stall, pop_m;
  int            issue_left, outstanding, buffered, burst_pops;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] prev_data, last_word;
  logic          prev_last;

  initial forever begin
    @(negedge clock);
    if (reset) begin
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_renable", ram_renable, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_raddr", ram_raddr, 0);
      exp_q.delete();
      busy_m = 0; pend_m = 0; prev_stall = 0;
      issue_left = 0; outstanding = 0; buffered = 0;
    end else begin
      pop_m = out_valid & out_ready;
      chk("busy_inverse", busy, !cmd_ready);
      chk("cmd_ready", cmd_ready, !busy_m);
      chk("renable", ram_renable, busy_m && issue_left != 0 && (outstanding - int'(pop_m)) < 2);
      if (ram_renable) chk("raddr", ram_raddr, exp_addr);
      chk("out_valid", out_valid, buffered != 0);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      if (out_valid) begin
        chk("word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("out_data", out_data, exp_q[0][DW-1:0]);
          chk("out_last", out_last, exp_q[0][DW]);
        end
      end
      if (pop_m && exp_q.size() > 0) begin
        last_word = exp_q[0][DW-1:0];
        burst_pops++;
        if (exp_q[0][DW]) busy_m = 0;
        void'(exp_q.pop_front());
      end
      buffered = buffered + int'(pend_m) - int'(pop_m);
      outstanding = outstanding + int'(ram_renable) - int'(pop_m);
      chk("no_overflow", outstanding <= 2, 1);
      pend_m = ram_renable;
      if (ram_renable) begin
        exp_addr = exp_addr + 8'd1;
        issue_left--;
      end
      prev_stall = out_valid & !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      if (cmd_valid && cmd_ready) begin
        busy_m = 1;
        exp_addr = cmd_addr;
        issue_left = int'(cmd_count) + 1;
        burst_pops = 0;
        for (int i = 0; i <= int'(cmd_count); i++)
          exp_q.push_back({i == int'(cmd_count), mem[8'(int'(cmd_addr) + i)]});
      end
    end
  end

  task automatic send_cmd(input logic [AW-1:0] a, input logic [AW-1:0] c);
    bit ok = 0;
    @(posedge clock);
    #1;
    cmd_valid = 1'b1; cmd_addr = a; cmd_count = c;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clock);
      ok = cmd_ready;
    end
    chk("cmd_accept_timeout", ok, 1);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clock);
      #1;
      ok = cmd_ready && !busy_m;
    end
    chk("idle_timeout", ok, 1);
  endtask

  task automatic wait_pops(input int n);
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clock);
      #1;
      ok = burst_pops >= n;
    end
    chk("pops_timeout", ok, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 10'($urandom);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // single word
    mem[8'h10] = 10'h155;
    rmode = 0;
    send_cmd(8'h10, 8'h00);
    @(negedge clock);
    chk("t1_renable", ram_renable, 1);
    chk("t1_raddr", ram_raddr, 'h10);
    @(negedge clock);
    chk("t1_not_yet_valid", out_valid, 0);
    chk("t1_renable_once", ram_renable, 0);
    @(negedge clock);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 'h155);
    chk("t1_last", out_last, 1);
    @(negedge clock);
    chk("t1_cmd_ready_back", cmd_ready, 1);
    wait_idle();

    // burst, no stall
    for (int k = 0; k < 4; k++) mem[8'h20 + k] = 10'(12'h120 + k);
    send_cmd(8'h20, 8'h03);
    repeat (2) @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("t2_valid", out_valid, 1);
      chk("t2_data", out_data, 'h120 + k);
      chk("t2_last", out_last, k == 3);
    end
    wait_idle();

    // backpressure with fixed pattern
    rmode = 1; pidx = 0;
    send_cmd(8'h20, 8'h03);
    wait_idle();
    chk("t3_pops", burst_pops, 4);
    chk("t3_last_word", last_word, 'h123);

    // wrap and maximum length with random backpressure
    rmode = 2;
    send_cmd(8'hFE, 8'hFF);
    wait_idle();
    chk("t4_pops", burst_pops, 256);
    chk("t4_last_word", last_word, mem[8'hFD]);

    // command while busy is ignored
    rmode = 3;
    send_cmd(8'h60, 8'h07);
    @(posedge clock);
    #1;
    cmd_valid = 1'b1; cmd_addr = 8'h70; cmd_count = 8'h02;
    repeat (6) @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    rmode = 0;
    wait_idle();
    chk("t5_pops", burst_pops, 8);
    chk("t5_last_word", last_word, mem[8'h67]);
    repeat (3) @(negedge clock);
    chk("t5_still_idle", cmd_ready, 1);

    // reset mid-burst
    send_cmd(8'h50, 8'h07);
    wait_pops(2);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_renable", ram_renable, 0);
    chk("t6_async_cmd_ready", cmd_ready, 1);
    chk("t6_async_busy", busy, 0);
    chk("t6_pops_before_reset", burst_pops, 2);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    send_cmd(8'h40, 8'h01);
    wait_idle();
    chk("t6_pops", burst_pops, 2);
    chk("t6_last_word", last_word, mem[8'h41]);

    // randomized bursts
    rmode = 2;
    for (int i = 0; i < 256; i++) mem[i] = 10'($urandom);
    for (int n = 0; n < 25; n++) begin
      send_cmd(8'($urandom), 8'($urandom_range(0, 20)));
      wait_idle();
    end

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
